imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_pkg.sv | 14 +
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared constants and the loader state type for the instruction-memory loader.
package imem_pkg;

  localparam int IMEM_BYTES = 64;
  localparam int IMEM_AW    = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory, big-endian.
// Optional IMEM_LOADER_CHECKSUM_EN adds a running XOR checksum output of accepted words.
module imem_loader
  import imem_pkg::*;
#(
  parameter int NUM_BYTES = IMEM_BYTES,
  parameter int BASE_ADDR = 0,
  localparam int AW = $clog2(NUM_BYTES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          word_valid,
  input  logic [31:0]   word_data,
  input  logic          word_last,
  output logic          word_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          overflow
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]   checksum
`endif
);

  // One extra counter bit so the end-of-memory value is representable.
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] BASE_C = CW'(BASE_ADDR);
  localparam logic [CW-1:0] END_C  = CW'(NUM_BYTES);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  loader_state_t state_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]    byte_idx_r;
  logic [31:0]   word_r;
  logic          last_r;
  logic [1:0]    next_idx_s;
  logic [7:0]    next_byte_s;
  logic          accept_s;

  assign accept_s = word_valid && word_ready;

  // Big-endian byte mux for the write slot following the current byte index.
  always_comb begin
    next_idx_s  = byte_idx_r + 2'd1;
    next_byte_s = 8'h00;
    case (next_idx_s)
      2'd0:    next_byte_s = word_r[31:24];
      2'd1:    next_byte_s = word_r[23:16];
      2'd2:    next_byte_s = word_r[15:8];
      2'd3:    next_byte_s = word_r[7:0];
      default: next_byte_s = 8'h00;
    endcase
  end

  // Loader FSM; every output is registered and set on the edge entering its cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= BASE_C;
      byte_idx_r <= 2'd0;
      word_r     <= 32'd0;
      last_r     <= 1'b0;
      word_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum   <= 32'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= WAIT_WORD;
            cnt_r      <= BASE_C;
            overflow   <= 1'b0;
            word_ready <= 1'b1;
            busy       <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum   <= 32'd0;
`endif
          end
        end
        WAIT_WORD: begin
          // The first byte goes out on the accepting edge to meet the N+1 write slot.
          if (accept_s) begin
            state_r    <= WRITE;
            word_r     <= word_data;
            last_r     <= word_last;
            byte_idx_r <= 2'd0;
            word_ready <= 1'b0;
            mem_we     <= 1'b1;
            mem_addr   <= cnt_r[AW-1:0];
            mem_wdata  <= word_data[31:24];
            cnt_r      <= cnt_r + ONE_C;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum   <= checksum ^ word_data;
`endif
          end
        end
        WRITE: begin
          if (byte_idx_r != 2'd3) begin
            byte_idx_r <= next_idx_s;
            mem_addr   <= cnt_r[AW-1:0];
            mem_wdata  <= next_byte_s;
            cnt_r      <= cnt_r + ONE_C;
          end else begin
            mem_we     <= 1'b0;
            byte_idx_r <= 2'd0;
            if (last_r) begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (cnt_r == END_C) begin
              state_r  <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              overflow <= 1'b1;
            end else begin
              state_r    <= WAIT_WORD;
              word_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          word_ready <= 1'b0;
          mem_we     <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-stream reference model.
module tb_imem_loader;

  localparam int NB = 64;

  logic        clk = 1'b0;
  logic        reset, start, word_valid, word_last;
  logic [31:0] word_data;
  logic        word_ready, mem_we, busy, done, overflow;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  logic [5:0]  log_addr[$];
  logic [7:0]  log_data[$];
  int          done_cnt = 0;
  logic        ov_at_done = 1'b0;
  logic        busy_at_done = 1'b0;
  logic        dbl_done = 1'b0;
  logic        done_prev = 1'b0;
  logic [31:0] cks_at_done = 32'd0;

  logic [31:0] words_q[$];
  bit          lasts_q[$];
  logic [5:0]  exp_addr[$];
  logic [7:0]  exp_data[$];
  logic        exp_ov;
  logic [31:0] exp_cks;

  imem_loader #(.NUM_BYTES(NB), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
    .word_ready(word_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .overflow(overflow)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Memory-side monitor: logs every byte write and the state seen at each done pulse.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
    if (done === 1'b1) begin
      done_cnt++;
      ov_at_done   = overflow;
      busy_at_done = busy;
      if (done_prev) dbl_done = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      cks_at_done = checksum;
`endif
    end
    done_prev = done;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    dbl_done = 1'b0;
  endtask

  // Reference: each accepted word becomes four big-endian bytes at consecutive addresses.
  task automatic build_expected();
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    exp_ov  = 1'b0;
    exp_cks = 32'd0;
    for (int i = 0; i < words_q.size(); i++) begin
      w = words_q[i];
      exp_cks ^= w;
      for (int j = 0; j < 4; j++) begin
        exp_addr.push_back(6'(4 * i + j));
        exp_data.push_back(w[31 - 8 * j -: 8]);
      end
      if (lasts_q[i]) break;
      if (4 * (i + 1) >= NB) begin
        exp_ov = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Offers one word, then checks the 4-cycle write window and word_ready at N+5.
  task automatic send_word(input logic [31:0] w, input bit l, input int gap,
                           input bit stray_start, input bit exp_more);
    int t;
    repeat (gap) step();
    word_valid = 1'b1;
    word_data  = w;
    word_last  = l;
    t = 0;
    while (word_ready !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    n_cmp++;
    if (word_ready !== 1'b1) begin
      $display("FAIL accept_timeout: word_ready=%b expected 1", word_ready);
      n_fail++;
      word_valid = 1'b0;
      return;
    end
    step();
    word_valid = 1'($urandom_range(0, 1));
    word_data  = $urandom;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (mem_we !== 1'b1) begin
        $display("FAIL write_window: cycle %0d mem_we=%b expected 1", k + 1, mem_we);
        n_fail++;
      end
      start = stray_start && (k == 1);
      step();
    end
    start      = 1'b0;
    word_valid = 1'b0;
    n_cmp++;
    if (word_ready !== exp_more || mem_we !== 1'b0) begin
      $display("FAIL ready_n5: word_ready=%b mem_we=%b expected %b 0", word_ready, mem_we, exp_more);
      n_fail++;
    end
  endtask

  task automatic wait_done(input int prev, input string tag);
    int t;
    t = 0;
    while (done_cnt == prev && t < 20) begin
      step();
      t++;
    end
    step();
    n_cmp++;
    if (done_cnt != prev + 1 || dbl_done !== 1'b0 || busy_at_done !== 1'b0) begin
      $display("FAIL %s_done: pulses=%0d wide=%b busy=%b expected 1 0 0", tag, done_cnt - prev, dbl_done, busy_at_done);
      n_fail++;
    end
  endtask

  task automatic run_load(input string tag, input int gap_max, input bit strays);
    int prev;
    bit more;
    build_expected();
    clear_logs();
    prev = done_cnt;
    do_start();
    for (int i = 0; i < words_q.size(); i++) begin
      more = !lasts_q[i] && (4 * (i + 1) != NB);
      send_word(words_q[i], lasts_q[i], $urandom_range(0, gap_max), strays && $urandom_range(0, 1) == 1, more);
      if (!more) break;
    end
    wait_done(prev, tag);
    n_cmp++;
    if (log_addr.size() != exp_addr.size()) begin
      $display("FAIL %s_count: got %0d writes expected %0d", tag, log_addr.size(), exp_addr.size());
      n_fail++;
    end
    for (int i = 0; i < log_addr.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
        $display("FAIL %s_byte: write %0d got %0h@%0h expected %0h@%0h", tag, i, log_data[i], log_addr[i], exp_data[i], exp_addr[i]);
        n_fail++;
      end
    end
    n_cmp++;
    if (ov_at_done !== exp_ov) begin
      $display("FAIL %s_overflow: got %b expected %b", tag, ov_at_done, exp_ov);
      n_fail++;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    n_cmp++;
    if (cks_at_done !== exp_cks) begin
      $display("FAIL %s_checksum: got %h expected %h", tag, cks_at_done, exp_cks);
      n_fail++;
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; word_valid = 1'b0; word_last = 1'b0; word_data = 32'd0;
    step();
    n_cmp++;
    if ({word_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow} !== 19'd0) begin
      $display("FAIL reset_outputs: got %b expected all zero", {word_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow});
      n_fail++;
    end
    reset = 1'b0;
    repeat (2) step();
    n_cmp++;
    if ({word_ready, mem_we, busy, done} !== 4'd0) begin
      $display("FAIL reset_idle: got %b expected 0000", {word_ready, mem_we, busy, done});
      n_fail++;
    end
  endtask

  task automatic test_example();
    logic [7:0] ref_bytes [8] = '{8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h01, 8'h13};
    words_q = '{32'h00500093, 32'h00A00113};
    lasts_q = '{1'b0, 1'b1};
    run_load("example", 0, 1'b0);
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      n_cmp++;
      if (log_addr[i] !== 6'(i) || log_data[i] !== ref_bytes[i]) begin
        $display("FAIL example_const: write %0d got %0h@%0d expected %0h@%0d", i, log_data[i], log_addr[i], ref_bytes[i], i);
        n_fail++;
      end
    end
  endtask

  task automatic test_random_loads();
    int n;
    for (int it = 0; it < 6; it++) begin
      words_q.delete();
      lasts_q.delete();
      n = (it % 3 == 2) ? 16 : $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        words_q.push_back($urandom);
        lasts_q.push_back((it % 3 != 2) && (i == n - 1));
      end
      run_load("random", 3, 1'b1);
    end
  endtask

  task automatic test_start_ignored();
    int prev;
    words_q = '{$urandom, $urandom, $urandom};
    lasts_q = '{1'b0, 1'b0, 1'b1};
    build_expected();
    clear_logs();
    prev = done_cnt;
    do_start();
    for (int i = 0; i < 3; i++) send_word(words_q[i], lasts_q[i], 0, 1'b1, i != 2);
    wait_done(prev, "stray_start");
    n_cmp++;
    if (log_addr.size() != 12) begin
      $display("FAIL stray_start_count: got %0d writes expected 12", log_addr.size());
      n_fail++;
    end
    for (int i = 0; i < log_addr.size() && i < 12; i++) begin
      n_cmp++;
      if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
        $display("FAIL stray_start_byte: write %0d got %0h@%0h expected %0h@%0h", i, log_data[i], log_addr[i], exp_data[i], exp_addr[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_overflow();
    bit seen_ready;
    words_q.delete();
    lasts_q.delete();
    for (int i = 0; i < 16; i++) begin
      words_q.push_back($urandom);
      lasts_q.push_back(1'b0);
    end
    run_load("overflow", 1, 1'b0);
    n_cmp++;
    if (log_addr.size() == 0 || log_addr[log_addr.size() - 1] !== 6'd63) begin
      $display("FAIL overflow_last_addr: got %0d writes expected final address 63", log_addr.size());
      n_fail++;
    end
    word_valid = 1'b1;
    seen_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (word_ready !== 1'b0) seen_ready = 1'b1;
      step();
    end
    word_valid = 1'b0;
    step();
    n_cmp++;
    if (seen_ready || log_addr.size() != 64 || overflow !== 1'b1) begin
      $display("FAIL overflow_sticky: ready_seen=%b writes=%0d overflow=%b expected 0 64 1", seen_ready, log_addr.size(), overflow);
      n_fail++;
    end
    do_start();
    n_cmp++;
    if (overflow !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL overflow_clear: overflow=%b busy=%b expected 0 1", overflow, busy);
      n_fail++;
    end
    #2 reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    int prev;
    clear_logs();
    words_q.delete();
    lasts_q.delete();
    prev = done_cnt;
    start = 1'b1;
    word_valid = 1'b1;
    word_last = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      n_cmp++;
      if (word_ready !== (k % 5 == 0) || mem_we !== (k % 5 != 0)) begin
        $display("FAIL b2b_pattern: cycle %0d ready=%b we=%b expected %b %b", k, word_ready, mem_we, k % 5 == 0, k % 5 != 0);
        n_fail++;
      end
      if (k % 5 == 0) begin
        word_data = $urandom;
        words_q.push_back(word_data);
        lasts_q.push_back(1'b0);
      end
      step();
    end
    word_data = $urandom;
    word_last = 1'b1;
    words_q.push_back(word_data);
    lasts_q.push_back(1'b1);
    step();
    word_valid = 1'b0;
    word_last  = 1'b0;
    wait_done(prev, "b2b");
    build_expected();
    n_cmp++;
    if (log_addr.size() != exp_addr.size()) begin
      $display("FAIL b2b_count: got %0d writes expected %0d", log_addr.size(), exp_addr.size());
      n_fail++;
    end
    for (int i = 0; i < log_addr.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
        $display("FAIL b2b_byte: write %0d got %0h@%0h expected %0h@%0h", i, log_data[i], log_addr[i], exp_data[i], exp_addr[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int prev;
    int t;
    words_q = '{$urandom, $urandom, $urandom};
    lasts_q = '{1'b0, 1'b0, 1'b0};
    build_expected();
    clear_logs();
    prev = done_cnt;
    do_start();
    send_word(words_q[0], 1'b0, 0, 1'b0, 1'b1);
    send_word(words_q[1], 1'b0, 0, 1'b0, 1'b1);
    word_valid = 1'b1;
    word_data  = words_q[2];
    t = 0;
    while (word_ready !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    step();
    word_valid = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({word_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow} !== 19'd0) begin
      $display("FAIL midreset_outputs: got %b expected all zero", {word_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow});
      n_fail++;
    end
    step();
    reset = 1'b0;
    repeat (5) step();
    n_cmp++;
    if (done_cnt != prev || busy !== 1'b0 || word_ready !== 1'b0 || log_addr.size() != 10) begin
      $display("FAIL midreset_idle: done=%0d busy=%b ready=%b writes=%0d expected 0 0 0 10", done_cnt - prev, busy, word_ready, log_addr.size());
      n_fail++;
    end
    for (int i = 0; i < log_addr.size() && i < 10; i++) begin
      n_cmp++;
      if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
        $display("FAIL midreset_byte: write %0d got %0h@%0h expected %0h@%0h", i, log_data[i], log_addr[i], exp_data[i], exp_addr[i]);
        n_fail++;
      end
    end
    words_q = '{$urandom};
    lasts_q = '{1'b1};
    run_load("restart", 2, 1'b0);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    words_q = '{32'h12345678, 32'hFFFF0000};
    lasts_q = '{1'b0, 1'b1};
    run_load("checksum", 1, 1'b0);
    n_cmp++;
    if (cks_at_done !== 32'hEDCB5678) begin
      $display("FAIL checksum_const: got %h expected edcb5678", cks_at_done);
      n_fail++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_example();
    test_random_loads();
    test_start_ignored();
    test_overflow();
    test_back_to_back();
    test_reset_mid_write();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
